v1_pulse_gen: RTL

Synthetic detector-pulse source: turns queued event amplitudes into a sampled stream of exponential tail pulses with a linear leading edge, one sample per clock. Sits in front of the trapezoidal shaper, taking the ADC's place, for closed-loop bring-up and regression.
Output format matches the shaper input, with a constant baseline and pile-up of overlapping pulses.

---
 rtl/v1_pulse_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/v1_pulse_gen.sv
// v1_pulse_gen -- synthetic detector-pulse source.
//
// Turns queued event amplitudes into a sampled stream of exponential-tail
// pulses with a linear leading edge, one sample per clock. The output sits
// on a constant baseline, and overlapping pulses pile up. The output format
// matches the trapezoidal shaper input, so this block can stand in for the
// ADC during bring-up and regression.
//
// Ports:
//   clk          clock
//   reset        synchronous reset, active-high
//   ev_valid     event request
//   ev_amp       pulse amplitude in output LSBs
//   ev_ready     event queue can accept (not full)
//   output_data  registered sample stream
//   busy         pulse in progress or events queued
//   fifo_level   number of queued events
//
// Optional build macro:
//   PULSE_GEN_NOISE_EN  adds LFSR dither in -4..+3 LSB to every sample
//                       (16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1)

module v1_pulse_gen #(
    parameter int SIZE_IN_DATA = 14,
    parameter int AMP_W        = 14,
    parameter int FRAC         = 8,
    parameter int TAU_SH       = 4,
    parameter int RISE_SH      = 2,
    parameter int HOLDOFF      = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int BASELINE     = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ev_valid,
    input  logic [AMP_W-1:0]              ev_amp,
    output logic                          ev_ready,
    output logic [SIZE_IN_DATA-1:0]       output_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int ACC_W    = AMP_W + FRAC + 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int RISE_LEN = 1 << RISE_SH;
    localparam int CNT_W    = (RISE_SH > 0) ? RISE_SH : 1;
    localparam int HOLD_W   = $clog2(HOLDOFF + 1);
    localparam int OUT_MAX  = (1 << SIZE_IN_DATA) - 1;
    // Below this the tail is considered finished and is snapped to zero.
    localparam logic [ACC_W-1:0] DECAY_FLOOR = ACC_W'(1) << (TAU_SH + FRAC);

    typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

    state_t                state, state_next;
    logic [ACC_W-1:0]      acc, acc_next;
    logic [ACC_W-1:0]      step_q, pop_step, add_val;
    logic [ACC_W:0]        sum;
    logic [ACC_W-1:0]      sat_sum;
    logic [HOLD_W-1:0]     holdoff;
    logic [CNT_W-1:0]      rise_cnt;
    logic [SIZE_IN_DATA-1:0] sample_next;
    logic signed [31:0]    samp_raw;
    logic signed [31:0]    noise;

    // ---------------------------------------------------------------
    // Event queue
    // ---------------------------------------------------------------
    logic [AMP_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push, pop;

    assign push = ev_valid && ev_ready;
    // A pulse can start once the previous leading edge is complete and the
    // hold-off window has elapsed; a decaying tail may be piled on.
    assign pop  = (level != '0) && (state != RISE) && (holdoff == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ev_amp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Per-edge rise increment: amplitude spread evenly over the leading edge.
    assign pop_step = {1'b0, mem[rd_ptr], {FRAC{1'b0}}} >> RISE_SH;

    // ---------------------------------------------------------------
    // Noise source
    // ---------------------------------------------------------------
`ifdef PULSE_GEN_NOISE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign noise = $signed({29'd0, lfsr[2:0]}) - 32'sd4;
`else
    assign noise = '0;
`endif

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        if (pop) begin
            state_next = (RISE_LEN == 1) ? DECAY : RISE;
        end else begin
            case (state)
                RISE:    if (rise_cnt == CNT_W'(1)) state_next = DECAY;
                DECAY:   if (acc < DECAY_FLOOR)     state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    // FSM: outputs and next-sample datapath
    always_comb begin
        ev_ready   = (level != LVL_W'(FIFO_DEPTH));
        busy       = (state != IDLE) || (level != '0);
        fifo_level = level;

        // The pop edge is itself the first add of the new leading edge.
        add_val = pop ? pop_step : step_q;
        sum     = {1'b0, acc} + {1'b0, add_val};
        sat_sum = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

        acc_next = acc;
        if (pop || state == RISE) begin
            acc_next = sat_sum;
        end else if (state == DECAY) begin
            // Floor test uses the pre-decay value.
            if (acc < DECAY_FLOOR) acc_next = '0;
            else                   acc_next = acc - (acc >> TAU_SH);
        end else begin
            acc_next = '0;
        end

        samp_raw = BASELINE + $signed(32'(acc_next[ACC_W-1:FRAC])) + noise;
        if (samp_raw < 0)
            sample_next = '0;
        else if (samp_raw > OUT_MAX)
            sample_next = SIZE_IN_DATA'(OUT_MAX);
        else
            sample_next = samp_raw[SIZE_IN_DATA-1:0];
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            step_q      <= '0;
            holdoff     <= '0;
            rise_cnt    <= '0;
            output_data <= SIZE_IN_DATA'(BASELINE);
        end else begin
            acc         <= acc_next;
            output_data <= sample_next;
            if (pop) begin
                step_q   <= pop_step;
                holdoff  <= HOLD_W'(HOLDOFF - 1);
                rise_cnt <= CNT_W'(RISE_LEN - 1);
            end else begin
                if (holdoff != '0) holdoff  <= holdoff - 1'b1;
                if (state == RISE) rise_cnt <= rise_cnt - 1'b1;
            end
        end
    end

endmodule
